demux1x5_stream: RTL and testbench

- Inverse of the team's 5x1 mux tree. Takes one input word stream and routes each word to one of five output channels, chosen by a 3-bit select or by an internal round-robin pointer.
- Each output channel has a one-entry holding register with a valid/ready handshake, so slow consumers backpressure the source.
- Sits after a shared serial/TDM source to fan words out to five per-lane consumers.

---
 rtl/demux1x5_stream.sv | 99 +++++++++
 tb/tb_demux1x5_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux1x5_stream.sv
// 1-to-5 word demux. A 3-bit select or an internal round-robin pointer picks the
// output channel. Each channel has a one-entry holding register with a valid/ready handshake.

module demux1x5_stream_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Load wins over drain, so back-to-back words on one channel leave no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

module demux1x5_stream #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [2:0]         sel,
   input  logic               auto_mode,
   output logic [4:0]         out_valid,
   input  logic [4:0]         out_ready,
   output logic [5*WIDTH-1:0] out_data,
   output logic [2:0]         rr_ptr
);

   localparam int NUM_LANES = 5;

   logic [2:0]                          dest;
   logic                                accept;
   logic [NUM_LANES-1:0]                load;
   logic [NUM_LANES-1:0][WIDTH-1:0]     lane_data;

   // Selects 4..7 all fold onto channel 4, matching the 5x1 mux tree.
   always_comb begin
      dest = 3'd0;
      if (auto_mode)
         dest = rr_ptr;
      else if (sel[2])
         dest = 3'd4;
      else
         dest = {1'b0, sel[1:0]};
   end

   assign in_ready = !rst && (!out_valid[dest] || out_ready[dest]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      load = '0;
      if (accept)
         load[dest] = 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         demux1x5_stream_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .din   (in_data),
            .ready (out_ready[g]),
            .valid (out_valid[g]),
            .data  (lane_data[g])
         );
      end
   endgenerate

   assign out_data = lane_data;

   // Pointer only moves on an accepted word, so a stalled channel is never skipped.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 3'd0;
      else if (accept && auto_mode)
         rr_ptr <= (rr_ptr == 3'd4) ? 3'd0 : rr_ptr + 3'd1;
   end

endmodule

// File: tb/tb_demux1x5_stream.sv
// Directed bench for demux1x5_stream: reset, manual routing, backpressure,
// round-robin routing, round-robin stall and mid-stream reset.

module tb_demux1x5_stream;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [2:0]         sel;
   logic               auto_mode;
   logic [4:0]         out_valid;
   logic [4:0]         out_ready;
   logic [5*WIDTH-1:0] out_data;
   logic [2:0]         rr_ptr;

   int vectors     = 0;
   int miscompares = 0;

   demux1x5_stream #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel       (sel),
      .auto_mode (auto_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .rr_ptr    (rr_ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lane(input int k);
      return out_data[k*WIDTH +: WIDTH];
   endfunction

   logic [2:0] man_ch [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
   logic [2:0] rr_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0;
      auto_mode = 1'b0; out_ready = 5'b11111;

      // Reset state
      tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 5'b00000);
      chk("rst_rr_ptr", rr_ptr, 3'd0);
      chk("rst_out_data", out_data, 40'h0);
      chk("rst_in_ready", in_ready, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_out_valid", out_valid, 5'b00000);

      // Manual routing, sel 0..7
      tick();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; sel = 3'(i); in_data = 8'hA0 + 8'(i);
         @(negedge clk);
         chk("man_in_ready", in_ready, 1'b1);
         tick();
         chk("man_out_valid", out_valid, 5'b00001 << man_ch[i]);
         chk("man_lane_data", lane(int'(man_ch[i])), 8'hA0 + 8'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("man_drained", out_valid, 5'b00000);
      chk("man_all_data", out_data, 40'hA7A3A2A1A0);
      chk("man_rr_hold", rr_ptr, 3'd0);

      // Backpressure on channel 2
      out_ready = 5'b11011; sel = 3'd2; in_valid = 1'b1; in_data = 8'h11;
      @(negedge clk);
      chk("bp_first_ready", in_ready, 1'b1);
      tick();
      chk("bp_first_valid", out_valid, 5'b00100);
      chk("bp_first_data", lane(2), 8'h11);
      in_data = 8'h22;
      @(negedge clk);
      chk("bp_second_blocked", in_ready, 1'b0);
      tick();
      chk("bp_hold_valid", out_valid, 5'b00100);
      chk("bp_hold_data", lane(2), 8'h11);
      out_ready = 5'b11111;
      @(negedge clk);
      chk("bp_release_ready", in_ready, 1'b1);
      tick();
      chk("bp_nobubble_valid", out_valid, 5'b00100);
      chk("bp_nobubble_data", lane(2), 8'h22);
      in_valid = 1'b0;
      tick();
      chk("bp_drained", out_valid, 5'b00000);

      // Round-robin, sel held at 7 to show it is ignored
      auto_mode = 1'b1; sel = 3'd7;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = 8'h30 + 8'(i);
         @(negedge clk);
         chk("rr_ptr_before", rr_ptr, rr_seq[i]);
         chk("rr_in_ready", in_ready, 1'b1);
         tick();
         chk("rr_out_valid", out_valid, 5'b00001 << rr_seq[i]);
         chk("rr_lane_data", lane(int'(rr_seq[i])), 8'h30 + 8'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("rr_ptr_end", rr_ptr, 3'd2);
      chk("rr_all_data", out_data, 40'h3433323635);

      // Round-robin stall: fill ch3 manually, step pointer to 3 via ch2
      auto_mode = 1'b0; sel = 3'd3; out_ready = 5'b10111;
      in_valid = 1'b1; in_data = 8'h40;
      tick();
      chk("st_fill_valid", out_valid, 5'b01000);
      chk("st_toggle_keeps_ptr", rr_ptr, 3'd2);
      auto_mode = 1'b1; in_data = 8'h41;
      tick();
      chk("st_ptr_at3", rr_ptr, 3'd3);
      chk("st_ch2_data", lane(2), 8'h41);
      in_data = 8'h42;
      @(negedge clk);
      chk("st_blocked_ready", in_ready, 1'b0);
      tick();
      tick();
      chk("st_ptr_held", rr_ptr, 3'd3);
      chk("st_valid_held", out_valid, 5'b01000);
      chk("st_data_stable", lane(3), 8'h40);
      out_ready = 5'b11111;
      @(negedge clk);
      chk("st_release_ready", in_ready, 1'b1);
      tick();
      chk("st_accept_data", lane(3), 8'h42);
      chk("st_accept_valid", out_valid, 5'b01000);
      chk("st_ptr_to4", rr_ptr, 3'd4);
      in_valid = 1'b0;
      tick();
      chk("st_drained", out_valid, 5'b00000);

      // Mid-operation reset: fill ch4, ch0, ch1 then drain ch0
      out_ready = 5'b00000; in_valid = 1'b1;
      in_data = 8'h50; tick();
      in_data = 8'h51; tick();
      in_data = 8'h52; tick();
      in_valid = 1'b0; out_ready = 5'b00001;
      tick();
      chk("mr_pre_valid", out_valid, 5'b10010);
      chk("mr_pre_ptr", rr_ptr, 3'd2);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h60; out_ready = 5'b00000;
      @(negedge clk);
      chk("mr_rst_in_ready", in_ready, 1'b0);
      tick();
      chk("mr_rst_valid", out_valid, 5'b00000);
      chk("mr_rst_ptr", rr_ptr, 3'd0);
      chk("mr_rst_data", out_data, 40'h0);
      rst = 1'b0; auto_mode = 1'b0; sel = 3'd1; in_data = 8'h61; out_ready = 5'b11111;
      @(negedge clk);
      chk("mr_resume_ready", in_ready, 1'b1);
      tick();
      chk("mr_resume_valid", out_valid, 5'b00010);
      chk("mr_resume_data", out_data, 40'h0000006100);
      chk("mr_resume_ptr", rr_ptr, 3'd0);
      in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
